// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter of per-source write-back FIFOs onto the
// single common data bus (ROB write-back and reservation-station wakeup).
// Each source buffers results in a small FIFO so losing arbitration never
// stalls it. One registered result is driven per ready cycle, and a pipeline
// clear discards everything buffered.
module cdb_arbiter #(
    parameter int NUM_SRC    = 3,  // 0 = ALU, 1 = LSB, 2 = BRU; 2..8
    parameter int FIFO_DEPTH = 2,  // power of two, >= 2
    parameter int ROB_IDX_W  = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          clear,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ROB_IDX_W-1:0]  src_rob_idx,
    input  logic [NUM_SRC*32-1:0]         src_value,
    output logic                          cdb_valid,
    output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
    output logic [31:0]                   cdb_value,
    output logic [2:0]                    cdb_src
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ROB_IDX_W + 32;

    // FIFO storage, entry = {rob_idx, value}
    logic [ENTRY_W-1:0]   r_mem    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr [NUM_SRC];
    logic [PTR_W-1:0]     r_rd_ptr [NUM_SRC];
    logic [CNT_W-1:0]     r_count  [NUM_SRC];
    logic [2:0]           r_last_grant;

    logic                 r_cdb_valid;
    logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
    logic [31:0]          r_cdb_value;
    logic [2:0]           r_cdb_src;

    logic [NUM_SRC-1:0]   w_ready;
    logic [NUM_SRC-1:0]   w_push;
    logic [NUM_SRC-1:0]   w_pop;
    logic                 w_found;
    logic                 w_fire;
    logic [2:0]           w_winner;
    logic [ENTRY_W-1:0]   w_head;

    // Accept logic: readiness is based on the registered count only, so a
    // full FIFO stays not-ready even in a cycle where it is being popped.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ready[i] = rdy_in && !clear && (r_count[i] < CNT_W'(FIFO_DEPTH));
            w_push[i]  = src_valid[i] && w_ready[i];
        end
    end

    assign src_ready = w_ready;

    // Round-robin search: first non-empty FIFO above last_grant, else wrap
    // around and take the first non-empty FIFO from index 0.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update,
        // so no path through this block can leave a latch behind.
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_head   = '0;
        w_pop    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && (r_count[i] != '0) && (3'(i) > r_last_grant)) begin
                w_found  = 1'b1;
                w_winner = 3'(i);
                w_head   = r_mem[i][r_rd_ptr[i]];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && (r_count[i] != '0)) begin
                w_found  = 1'b1;
                w_winner = 3'(i);
                w_head   = r_mem[i][r_rd_ptr[i]];
            end
        end
        w_fire = rdy_in && !clear && w_found;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_pop[i] = w_fire && (w_winner == 3'(i));
        end
    end

    // FIFO payload write on accepted pushes.
    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the counts and pointers, so clearing the data itself is never needed.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= {src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                                          src_value[i*32 +: 32]};
            end
        end
    end

    // Control state: pointers, counts, grant pointer and registered cdb.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_last_grant  <= 3'(NUM_SRC - 1);
            r_cdb_valid   <= 1'b0;
            r_cdb_rob_idx <= '0;
            r_cdb_value   <= '0;
            r_cdb_src     <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                // Flush: drop buffered results, keep the fairness pointer.
                for (int i = 0; i < NUM_SRC; i++) begin
                    r_wr_ptr[i] <= '0;
                    r_rd_ptr[i] <= '0;
                    r_count[i]  <= '0;
                end
                r_cdb_valid <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                    if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                    r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
                end
                r_cdb_valid <= w_found;
                if (w_found) begin
                    r_cdb_rob_idx <= w_head[ENTRY_W-1:32];
                    r_cdb_value   <= w_head[31:0];
                    r_cdb_src     <= w_winner;
                    r_last_grant  <= w_winner;
                end
            end
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_rob_idx = r_cdb_rob_idx;
    assign cdb_value   = r_cdb_value;
    assign cdb_src     = r_cdb_src;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates write-back results from several execution sources (ALU, LSB load, branch unit) onto the single common data bus. The common data bus feeds the reorder buffer's write-back port and the reservation-station wakeup logic. Each source has a small FIFO, so a source is not stalled when it loses arbitration. The block grants round-robin, drives one registered result per cycle, and discards all buffered results on a pipeline clear.

## Interface
Parameters:
- NUM_SRC, 3: number of requesting sources (0 = ALU, 1 = LSB, 2 = BRU); valid range 2..8.
- FIFO_DEPTH, 2: entries per source FIFO; power of two, ≥2.
- ROB_IDX_W, 4: width of a ROB index.

Ports:
- clk_in, input, 1: system clock; all state updates on the rising edge.
- rst_in, input, 1: reset, asynchronous, active-low.
- rdy_in, input, 1: global ready; when low, the block freezes.
- clear, input, 1: pipeline flush from the reorder buffer (mispredict).
- src_valid, input, NUM_SRC: per-source result valid.
- src_ready, output, NUM_SRC: per-source accept, combinational.
- src_rob_idx, input, NUM_SRC*ROB_IDX_W: packed ROB indices; source i occupies bits [i*ROB_IDX_W +: ROB_IDX_W].
- src_value, input, NUM_SRC*32: packed result values; source i occupies bits [i*32 +: 32].
- cdb_valid, output, 1: registered result valid.
- cdb_rob_idx, output, ROB_IDX_W: registered ROB index.
- cdb_value, output, 32: registered value.
- cdb_src, output, 3: index of the source that was granted.

## Operation
Reset (rst_in low, asynchronous):
- FIFO counts and pointers = 0.
- cdb_valid = 0, cdb_rob_idx = 0, cdb_value = 0, cdb_src = 0.
- Round-robin pointer last_grant = NUM_SRC-1, so source 0 has first priority.

Accept:
- src_ready[i] = rdy_in && !clear && count[i] < FIFO_DEPTH.
- Source i pushes {rob_idx, value} at the edge where src_valid[i] && src_ready[i].
- A full FIFO keeps src_ready low even in a cycle where it is being popped; readiness is not bypassed.

Arbitration (every cycle with rdy_in high and clear low):
- Candidates are the sources with non-empty FIFOs, sampled before this edge's pushes.
- Search order is last_grant+1, last_grant+2, … mod NUM_SRC; the first non-empty FIFO wins.
- The winning FIFO's head is popped and registered onto the cdb outputs; cdb_valid = 1, cdb_src = winner, last_grant = winner.
- If no FIFO is non-empty: cdb_valid = 0, and cdb_rob_idx / cdb_value / cdb_src / last_grant hold.
- A push and a pop on the same FIFO in the same cycle are legal; the count is unchanged.

Clear (clear high with rdy_in high):
- At the edge, all FIFOs empty and cdb_valid goes to 0.
- src_ready is 0 during the clear cycle, so results offered in that cycle are dropped.
- last_grant is preserved.

Stall (rdy_in low):
- No push, pop, or clear takes effect.
- All outputs hold; src_ready is 0.

Pointer and width rules:
- FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- count is log2(FIFO_DEPTH)+1 bits.
- Per-source ordering is strictly FIFO; no ordering is guaranteed across sources.

## Timing
- Latency from acceptance edge E to first appearance on cdb is 1 edge: the result is visible after edge E+1 if it wins.
- Throughput is one result per rdy_in-high cycle in total.
- Worst-case wait for a non-empty source is NUM_SRC-1 grants.
- cdb_valid is a one-rdy-cycle pulse per result. Consumers sample it only on edges where rdy_in is high, so a held value during a stall is consumed exactly once.
- clear and rst_in take precedence over all other events in the same cycle.
- rst_in asserted mid-operation discards all FIFO contents immediately.

## Test plan
- Single result: ALU pushes idx 5, value 0x1234 at edge 1. Cycle after edge 2: cdb_valid=1, idx=5, value=0x1234, cdb_src=0. Next cycle: cdb_valid=0.
- Round-robin: all 3 sources push once at the same edge. Grants in order src 0, 1, 2 on consecutive cycles. A second triple pushed afterward is also granted in order 0, 1, 2 (last_grant=2 wraps to 0).
- FIFO full: LSB pushes 2 results while ALU keeps the grant busy. src_ready[1] must read 0 with count=2. A third push is refused, and the source holds its value until accepted. Values emerge in push order.
- Clear: 4 results buffered across sources, then clear pulsed for 1 cycle. Next cycle: cdb_valid=0 and all src_ready=1. Results offered during the clear cycle never appear on cdb.
- Stall: rdy_in low for 3 cycles while cdb_valid=1 (idx 7). Outputs hold, src_ready=0, FIFO counts unchanged. After rdy_in rises, idx 7 is consumed once and the next entry follows.
- Async reset mid-stream: drive rst_in low between edges. cdb_valid drops immediately and all counts read 0. After release, the first grant goes to src 0.
